// File: rtl/rsv_fetch_buf.sv
// rsv_fetch_buf -- pipelined instruction fetch with a DEPTH-entry PC-tagged
// instruction buffer.
//
// Owns the fetch PC, issues word-aligned reads over a req/gnt/rvalid
// interface with up to DEPTH reads in flight, tags each returned word with
// its PC and queues it for decode (valid/ready).  A redirect flushes the
// buffer, restarts fetch at the new PC and discards in-flight responses.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   redirect_i/redirect_pc_i flush and restart fetch (pc[1:0] ignored)
//   fetch_mem_req_o/addr_o   registered read request and its address
//   fetch_mem_gnt_i          memory accepts the request this cycle
//   mem_rvalid_i/rd_inst_i   in-order read response
//   inst_valid_o/inst_o/inst_pc_o  buffer head (instruction and PC read 0 when empty)
//   inst_ready_i             decode consumes the head
//   perf_starve_cnt_o        only with RSV_FETCH_PERF_EN: saturating count of
//                            cycles with decode ready but no instruction
module rsv_fetch_buf #(
    parameter int unsigned          XLEN     = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            fetch_mem_req_o,
    output logic [XLEN-1:0] fetch_mem_addr_o,
    input  logic            fetch_mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [31:0]     mem_rd_inst_i,
    output logic            inst_valid_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
`ifdef RSV_FETCH_PERF_EN
    ,
    output logic [31:0]     perf_starve_cnt_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    cnt_t            out_q, out_d;
    cnt_t            kill_q, kill_d;
    cnt_t            cnt_q, cnt_d;
    ptr_t            fifo_wr_q, fifo_rd_q;
    ptr_t            tag_wr_q, tag_rd_q;

    logic [31:0]     fifo_inst [DEPTH];
    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [XLEN-1:0] tag_pc    [DEPTH];

    logic            accept, ret, keep, pop;
    logic [CW:0]     credit_sum;
    logic            unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc_i[1:0];

    assign accept = req_q & fetch_mem_gnt_i;
    // A response with nothing outstanding is a leftover from before reset.
    assign ret    = mem_rvalid_i & (out_q != '0);
    assign keep   = ret & (kill_q == '0) & ~redirect_i;
    assign pop    = (cnt_q != '0) & inst_ready_i & ~redirect_i;

    always_comb begin
        out_d  = out_q + cnt_t'(accept) - cnt_t'(ret);
        kill_d = kill_q;
        cnt_d  = cnt_q + cnt_t'(keep) - cnt_t'(pop);
        pc_d   = pc_q;
        if (accept)
            pc_d = pc_q + XLEN'(4);
        if (ret && kill_q != '0)
            kill_d = kill_q - cnt_t'(1);
        if (redirect_i) begin
            // Everything still in flight after this cycle's grant/return is stale.
            kill_d = out_d;
            cnt_d  = '0;
            pc_d   = {redirect_pc_i[XLEN-1:2], 2'b00};
        end
        // Request is registered, so the credit check looks at next-cycle occupancy.
        credit_sum = {1'b0, cnt_d} + {1'b0, out_d};
        req_d      = credit_sum < DEPTH_W;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= {RESET_PC[XLEN-1:2], 2'b00};
            req_q     <= 1'b0;
            out_q     <= '0;
            kill_q    <= '0;
            cnt_q     <= '0;
            fifo_wr_q <= '0;
            fifo_rd_q <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            req_q  <= req_d;
            out_q  <= out_d;
            kill_q <= kill_d;
            cnt_q  <= cnt_d;
            // Tag pointers advance on every grant and every return, stale or
            // not, so they stay aligned with the in-order response stream
            // across redirects without extra bookkeeping.
            if (accept)
                tag_wr_q <= tag_wr_q + ptr_t'(1);
            if (ret)
                tag_rd_q <= tag_rd_q + ptr_t'(1);
            if (redirect_i) begin
                fifo_wr_q <= '0;
                fifo_rd_q <= '0;
            end else begin
                if (keep)
                    fifo_wr_q <= fifo_wr_q + ptr_t'(1);
                if (pop)
                    fifo_rd_q <= fifo_rd_q + ptr_t'(1);
            end
        end
    end

    // Storage arrays carry no reset; emptiness is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (accept)
            tag_pc[tag_wr_q] <= pc_q;
        if (keep) begin
            fifo_inst[fifo_wr_q] <= mem_rd_inst_i;
            fifo_pc[fifo_wr_q]   <= tag_pc[tag_rd_q];
        end
    end

    assign fetch_mem_req_o  = req_q;
    assign fetch_mem_addr_o = pc_q;
    assign inst_valid_o     = (cnt_q != '0);
    assign inst_o           = inst_valid_o ? fifo_inst[fifo_rd_q] : '0;
    assign inst_pc_o        = inst_valid_o ? fifo_pc[fifo_rd_q]   : '0;

`ifdef RSV_FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_starve_cnt_o <= '0;
        else if (inst_ready_i && !inst_valid_o && perf_starve_cnt_o != '1)
            perf_starve_cnt_o <= perf_starve_cnt_o + 32'd1;
    end
`endif

endmodule
